// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the CPU-to-DDR memory controller.
package mem_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RD_REQ,
    RD_WAIT
  } state_t;

endpackage

// File: rtl/ddr_mem_controller.sv
// Bridges single-cycle CPU read/write pulses onto a one-command-at-a-time DDR
// request/valid interface; read data returns with a one-cycle valid strobe.
module ddr_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_wr_req,
  input  logic                  cpu_rd_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic                  cpu_data_valid,
  output logic                  ddr_wr_req,
  output logic                  ddr_rd_req,
  output logic [ADDR_WIDTH-1:0] ddr_addr,
  output logic [DATA_WIDTH-1:0] ddr_wr_data,
  input  logic [DATA_WIDTH-1:0] ddr_rd_data,
  input  logic                  ddr_rd_valid
);

  state_t                state, state_next;
  logic                  wr_req_next, rd_req_next, valid_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] wdata_next, dout_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      ddr_wr_req     <= 1'b0;
      ddr_rd_req     <= 1'b0;
      ddr_addr       <= '0;
      ddr_wr_data    <= '0;
      cpu_data_out   <= '0;
      cpu_data_valid <= 1'b0;
    end else begin
      state          <= state_next;
      ddr_wr_req     <= wr_req_next;
      ddr_rd_req     <= rd_req_next;
      ddr_addr       <= addr_next;
      ddr_wr_data    <= wdata_next;
      cpu_data_out   <= dout_next;
      cpu_data_valid <= valid_next;
    end
  end

  always_comb begin
    state_next  = state;
    wr_req_next = 1'b0;
    rd_req_next = 1'b0;
    valid_next  = 1'b0;
    addr_next   = ddr_addr;
    wdata_next  = ddr_wr_data;
    dout_next   = cpu_data_out;

    case (state)
      IDLE: begin
        // Write has priority; a coincident read pulse is dropped.
        if (cpu_wr_req) begin
          addr_next   = cpu_addr;
          wdata_next  = cpu_data_in;
          wr_req_next = 1'b1;
          state_next  = WRITE;
        end else if (cpu_rd_req) begin
          addr_next   = cpu_addr;
          rd_req_next = 1'b1;
          state_next  = RD_REQ;
        end
      end
      WRITE: state_next = IDLE;
      RD_REQ, RD_WAIT: begin
        // A response already present in RD_REQ completes the read immediately.
        if (ddr_rd_valid) begin
          dout_next  = ddr_rd_data;
          valid_next = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = RD_WAIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ddr_mem_controller.sv
// Randomized bench for ddr_mem_controller with a transaction-level memory model
// and a one-cycle registered DDR responder.
module tb_ddr_mem_controller;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_wr_req, cpu_rd_req;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data_in;
  logic [DW-1:0] cpu_data_out;
  logic          cpu_data_valid;
  logic          ddr_wr_req, ddr_rd_req;
  logic [AW-1:0] ddr_addr;
  logic [DW-1:0] ddr_wr_data;
  logic [DW-1:0] ddr_rd_data;
  logic          ddr_rd_valid;
  logic          stray;

  logic [DW-1:0] dmem    [1024];
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] last_read;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata;

  int checks   = 0;
  int failures = 0;

  ddr_mem_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_wr_req     (cpu_wr_req),
    .cpu_rd_req     (cpu_rd_req),
    .cpu_addr       (cpu_addr),
    .cpu_data_in    (cpu_data_in),
    .cpu_data_out   (cpu_data_out),
    .cpu_data_valid (cpu_data_valid),
    .ddr_wr_req     (ddr_wr_req),
    .ddr_rd_req     (ddr_rd_req),
    .ddr_addr       (ddr_addr),
    .ddr_wr_data    (ddr_wr_data),
    .ddr_rd_data    (ddr_rd_data),
    .ddr_rd_valid   (ddr_rd_valid)
  );

  always #5 clk = ~clk;

  // DDR model: registers its response on the edge it sees a command.
  always @(posedge clk) begin
    ddr_rd_valid <= ddr_rd_req || stray;
    ddr_rd_data  <= ddr_rd_req ? dmem[ddr_addr] : $urandom;
    if (ddr_wr_req) dmem[ddr_addr] <= ddr_wr_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cpu_wr_req = 1'b0;
    cpu_rd_req = 1'b0;
  endtask

  task automatic drive_junk();
    cpu_wr_req  = 1'($urandom_range(0, 1));
    cpu_rd_req  = 1'($urandom_range(0, 1));
    cpu_addr    = AW'($urandom_range(0, 1023));
    cpu_data_in = $urandom;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit both, input bit noise);
    cpu_wr_req  = 1'b1;
    cpu_rd_req  = both;
    cpu_addr    = a;
    cpu_data_in = d;
    tick();
    drive_idle();
    if (noise) drive_junk();
    check("wr_cmd", 32'(ddr_wr_req), 32'd1);
    check("wr_no_rd", 32'(ddr_rd_req), 32'd0);
    check("wr_addr", 32'(ddr_addr), 32'(a));
    check("wr_data", ddr_wr_data, d);
    check("wr_no_valid", 32'(cpu_data_valid), 32'd0);
    tick();
    drive_idle();
    check("wr_cmd_drop", 32'(ddr_wr_req), 32'd0);
    check("wr_busy_ignored", 32'(ddr_rd_req), 32'd0);
    check("wr_addr_hold", 32'(ddr_addr), 32'(a));
    check("wr_data_hold", ddr_wr_data, d);
    check("wr_no_valid2", 32'(cpu_data_valid), 32'd0);
    check("wr_dout_hold", cpu_data_out, last_read);
    ref_mem[a] = d;
    last_addr  = a;
    last_wdata = d;
  endtask

  // Returns in the cycle the strobe is high, so a following call is back-to-back.
  task automatic do_read(input logic [AW-1:0] a, input bit noise);
    cpu_rd_req = 1'b1;
    cpu_wr_req = 1'b0;
    cpu_addr   = a;
    tick();
    drive_idle();
    if (noise) drive_junk();
    check("rd_cmd", 32'(ddr_rd_req), 32'd1);
    check("rd_no_wr", 32'(ddr_wr_req), 32'd0);
    check("rd_addr", 32'(ddr_addr), 32'(a));
    check("rd_wdata_hold", ddr_wr_data, last_wdata);
    tick();
    if (noise) drive_junk();
    check("rd_cmd_drop", 32'(ddr_rd_req), 32'd0);
    check("rd_busy_ignored", 32'(ddr_wr_req), 32'd0);
    check("rd_addr_hold", 32'(ddr_addr), 32'(a));
    check("rd_early_valid", 32'(cpu_data_valid), 32'd0);
    tick();
    drive_idle();
    check("rd_valid", 32'(cpu_data_valid), 32'd1);
    check("rd_data", cpu_data_out, ref_mem[a]);
    check("rd_busy_ignored2", 32'(ddr_wr_req | ddr_rd_req), 32'd0);
    last_read = ref_mem[a];
    last_addr = a;
  endtask

  task automatic idle_stray();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick();
    check("stray_no_valid", 32'(cpu_data_valid), 32'd0);
    tick();
    check("stray_no_valid2", 32'(cpu_data_valid), 32'd0);
    check("stray_dout_hold", cpu_data_out, last_read);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr"}, 32'(ddr_wr_req), 32'd0);
    check({tag, "_rd"}, 32'(ddr_rd_req), 32'd0);
    check({tag, "_addr"}, 32'(ddr_addr), 32'd0);
    check({tag, "_wdata"}, ddr_wr_data, 32'd0);
    check({tag, "_dout"}, cpu_data_out, 32'd0);
    check({tag, "_valid"}, 32'(cpu_data_valid), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int unsigned   op;

    reset = 1'b0;
    stray = 1'b0;
    drive_idle();
    cpu_addr    = '0;
    cpu_data_in = '0;
    for (int i = 0; i < 1024; i++) begin
      d          = $urandom;
      dmem[i]    = d;
      ref_mem[i] = d;
    end
    dmem[10]    = 32'hCAFEBABE;
    ref_mem[10] = 32'hCAFEBABE;
    last_read   = '0;
    last_wdata  = '0;
    last_addr   = '0;

    tick();
    check_all_zero("rst1");
    tick();
    check_all_zero("rst2");
    reset = 1'b1;
    tick();
    check_all_zero("post_rst");

    do_write(10'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    do_read(10'd5, 1'b0);
    do_read(10'd10, 1'b0);
    tick();
    check("b2b_strobe_single", 32'(cpu_data_valid), 32'd0);

    do_write(10'd7, 32'h12345678, 1'b1, 1'b0);
    do_read(10'd7, 1'b0);
    tick();

    // Abandon a read while it waits for the DDR response.
    cpu_rd_req = 1'b1;
    cpu_addr   = 10'd10;
    tick();
    drive_idle();
    check("rst_rd_cmd", 32'(ddr_rd_req), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    check_all_zero("midrst");
    reset      = 1'b1;
    last_read  = '0;
    last_wdata = '0;
    tick();
    check("midrst_no_valid", 32'(cpu_data_valid), 32'd0);
    check("midrst_dout", cpu_data_out, 32'd0);
    do_read(10'd10, 1'b0);
    idle_stray();

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(0, 1023));
      else                           a = AW'($urandom_range(0, 15));
      d = $urandom;
      case (op)
        0, 1: do_write(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        2, 3: do_read(a, 1'($urandom_range(0, 1)));
        default: idle_stray();
      endcase
    end
    tick();
    check("final_no_valid", 32'(cpu_data_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
